// File: rtl/double_to_long.sv
// IEEE-754 binary64 to signed 64-bit integer converter (round toward zero),
// stb/ack handshake on both sides, iterative one-bit-per-cycle alignment.
module double_to_long (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [63:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        GET_A,
        UNPACK,
        ALIGN,
        SIGN,
        PUT_Z
    } state_t;

    state_t             state_reg, state_next;
    logic [63:0]        a_reg, a_next;
    logic [63:0]        m_reg, m_next;
    logic [63:0]        z_reg, z_next;
    logic signed [11:0] e_reg, e_next;
    logic               s_reg, s_next;
    logic               ack_reg, ack_next;
    logic               stb_reg, stb_next;
    logic signed [11:0] e_unbiased;

    assign e_unbiased   = $signed({1'b0, a_reg[62:52]}) - 12'sd1023;
    assign input_a_ack  = ack_reg;
    assign output_z     = z_reg;
    assign output_z_stb = stb_reg;

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        m_next     = m_reg;
        z_next     = z_reg;
        e_next     = e_reg;
        s_next     = s_reg;
        ack_next   = ack_reg;
        stb_next   = stb_reg;
        case (state_reg)
            GET_A: begin
                ack_next = 1'b1;
                if (input_a_stb && ack_reg) begin
                    a_next     = input_a;
                    ack_next   = 1'b0;
                    state_next = UNPACK;
                end
            end
            UNPACK: begin
                s_next = a_reg[63];
                e_next = e_unbiased;
                m_next = {1'b1, a_reg[51:0], 11'b0};
                if (a_reg[62:52] == 11'h7FF) begin
                    z_next     = 64'h8000_0000_0000_0000;
                    stb_next   = 1'b1;
                    state_next = PUT_Z;
                end else if (e_unbiased < 12'sd0) begin
                    z_next     = 64'd0;
                    stb_next   = 1'b1;
                    state_next = PUT_Z;
                end else if (e_unbiased > 12'sd62) begin
                    // Also the encoding of exactly -2^63, so no special case needed.
                    z_next     = 64'h8000_0000_0000_0000;
                    stb_next   = 1'b1;
                    state_next = PUT_Z;
                end else begin
                    state_next = ALIGN;
                end
            end
            ALIGN: begin
                if (e_reg < 12'sd63) begin
                    m_next = m_reg >> 1;
                    e_next = e_reg + 12'sd1;
                end else begin
                    state_next = SIGN;
                end
            end
            SIGN: begin
                z_next     = s_reg ? -m_reg : m_reg;
                stb_next   = 1'b1;
                state_next = PUT_Z;
            end
            PUT_Z: begin
                if (stb_reg && output_z_ack) begin
                    stb_next   = 1'b0;
                    state_next = GET_A;
                end
            end
            default: begin
                state_next = GET_A;
                ack_next   = 1'b0;
                stb_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= GET_A;
            a_reg     <= 64'd0;
            m_reg     <= 64'd0;
            z_reg     <= 64'd0;
            e_reg     <= 12'sd0;
            s_reg     <= 1'b0;
            ack_reg   <= 1'b0;
            stb_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            m_reg     <= m_next;
            z_reg     <= z_next;
            e_reg     <= e_next;
            s_reg     <= s_next;
            ack_reg   <= ack_next;
            stb_reg   <= stb_next;
        end
    end

endmodule

// File: tb/tb_double_to_long.sv
// Bench for double_to_long: directed latency/backpressure/reset cases, then a
// random stream checked in order against a reference truncating cast.
module tb_double_to_long;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] input_a = 64'd0;
    logic        input_a_stb = 1'b0;
    logic        input_a_ack;
    logic [63:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack = 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] sb[$];

    localparam int N_STREAM = 1000;
    localparam logic [63:0] MIN_LONG = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [63:0] a;
        logic [63:0] z;
        int          lat;
        int          hold;
    } vec_t;

    double_to_long dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference C (long) cast built from the mantissa and exponent directly.
    function automatic logic [63:0] ref_cast(input logic [63:0] d);
        int          ex;
        logic [63:0] mag;
        ex = int'(d[62:52]);
        if (ex == 2047) return MIN_LONG;
        ex = ex - 1023;
        if (ex < 0) return 64'd0;
        if (ex > 62) return MIN_LONG;
        mag = {11'b0, 1'b1, d[51:0]};
        if (ex >= 52) mag = mag << (ex - 52);
        else mag = mag >> (52 - ex);
        return d[63] ? -mag : mag;
    endfunction

    function automatic logic [63:0] rand_double();
        logic [63:0] d;
        logic [10:0] ex;
        d = {$urandom, $urandom};
        case ($urandom % 8)
            0:       ex = 11'h7FF;
            1:       ex = 11'($urandom_range(0, 1022));
            default: ex = 11'(1023 + $urandom_range(0, 66));
        endcase
        d[62:52] = ex;
        return d;
    endfunction

    task automatic wait_ack();
        for (int i = 0; i < 200 && !input_a_ack; i++) begin
            @(posedge clk); #1;
        end
        if (!input_a_ack) check("ack_timeout", 64'(input_a_ack), 64'd1);
    endtask

    task automatic run_one(input vec_t v);
        int lat;
        bit seen;
        wait_ack();
        input_a = v.a;
        input_a_stb = 1'b1;
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        sb.push_back(v.z);
        lat = 0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (output_z_stb) seen = 1;
        end
        if (!seen) begin
            check("stb_timeout", 64'd0, 64'd1);
            void'(sb.pop_front());
            return;
        end
        check("latency", 64'(lat), 64'(v.lat));
        check("result", output_z, sb.pop_front());
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            check("hold_z", output_z, v.z);
            check("hold_stb", 64'(output_z_stb), 64'd1);
            check("hold_in_ack", 64'(input_a_ack), 64'd0);
        end
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        output_z_ack = 1'b0;
        check("stb_drop", 64'(output_z_stb), 64'd0);
        check("ack_still_low", 64'(input_a_ack), 64'd0);
        @(posedge clk); #1;
        check("ack_rise", 64'(input_a_ack), 64'd1);
    endtask

    vec_t vecs[10] = '{
        '{64'h3FF0000000000000, 64'd1,                  66, 0},
        '{64'hC004000000000000, 64'hFFFFFFFFFFFFFFFE,   65, 0},
        '{64'h3FE8000000000000, 64'd0,                   1, 0},
        '{64'h8000000000000000, 64'd0,                   1, 0},
        '{64'h43D0000000000000, 64'h4000000000000000,    4, 0},
        '{64'h43E0000000000000, MIN_LONG,                1, 0},
        '{64'hC3E0000000000000, MIN_LONG,                1, 0},
        '{64'h7FF0000000000000, MIN_LONG,                1, 0},
        '{64'h7FF8000000000000, MIN_LONG,                1, 0},
        '{64'hC004000000000000, 64'hFFFFFFFFFFFFFFFE,   65, 20}
    };

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        int recv;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ack", 64'(input_a_ack), 64'd0);
        check("rst_out_stb", 64'(output_z_stb), 64'd0);
        check("rst_out_z", output_z, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("first_ack", 64'(input_a_ack), 64'd1);

        foreach (vecs[i]) run_one(vecs[i]);

        // Abort a conversion of 1.0 partway through alignment.
        wait_ack();
        input_a = 64'h3FF0000000000000;
        input_a_stb = 1'b1;
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("mid_rst_stb", 64'(output_z_stb), 64'd0);
        check("mid_rst_ack", 64'(input_a_ack), 64'd0);
        check("mid_rst_z", output_z, 64'd0);
        run_one('{64'h4008000000000000, 64'd3, 65, 0});

        // Random stream with random gaps and random consumer backpressure.
        sent = 0;
        recv = 0;
        @(negedge clk);
        fork
            begin
                while (sent < N_STREAM) begin
                    @(negedge clk);
                    if (input_a_ack && ($urandom % 4 != 0)) begin
                        input_a = rand_double();
                        input_a_stb = 1'b1;
                        sb.push_back(ref_cast(input_a));
                        sent++;
                    end else begin
                        input_a_stb = 1'b0;
                    end
                end
                @(negedge clk);
                input_a_stb = 1'b0;
            end
            begin
                while (recv < N_STREAM) begin
                    @(negedge clk);
                    output_z_ack = ($urandom % 4 != 0);
                    if (output_z_stb && output_z_ack) begin
                        if (sb.size() == 0) check("stream_unexpected", output_z, 64'd0);
                        else check("stream", output_z, sb.pop_front());
                        recv++;
                    end
                end
                @(negedge clk);
                output_z_ack = 1'b0;
            end
        join
        check("stream_count", 64'(recv), 64'(sent));
        check("stream_leftover", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
